// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode seven-segment scan driver.
//
// It scans NUM_DIGITS digits, giving each digit a slot of TICK_DIV clock cycles.
// At each frame boundary it latches all display inputs into shadow registers,
// so that every frame shows one coherent snapshot. It also supports PWM
// brightness, per-digit enables and per-digit decimal points.
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
// digits. Blanking is computed on the shadow copy.
//
// Ports:
//   aclk         system clock
//   aresetn      synchronous active-low reset
//   value        hex nibbles, digit k = value[4k+3:4k], digit 0 rightmost
//   dp_in        decimal point request per digit (active high)
//   digit_en     digit enable mask (0 blanks the digit)
//   brightness   PWM duty, 0 = dark, all-ones = full on
//   an           anode selects, active low, one-hot-low when visible
//   seg          segments {a,b,c,d,e,f,g}, active low
//   dp           decimal point segment, active low
//   frame_start  one-cycle pulse on the cycle the shadow registers load
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned TICK_DIV   = 200000,
  parameter int unsigned BRIGHT_W   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  logic                  start_q, start_d;
  logic [VAL_W-1:0]      val_sh_q, val_sh_d;
  logic [NUM_DIGITS-1:0] dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0] en_sh_q, en_sh_d;
  logic [BRIGHT_W-1:0]   br_sh_q, br_sh_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_start_q, frame_start_d;

  logic                  tick_c, last_c, load_c;
  logic [3:0]            nib_c;
  logic                  en_bit_c, dp_bit_c, blank_bit_c, gate_c, vis_c;
  logic [NUM_DIGITS-1:0] blank_c;

  // Counters and frame-coherent shadow load.
  // While start_q is set, the counters hold at 0 so that the first frame after
  // reset has full-length slots.
  always_comb begin
    tick_c   = (presc_q == PRESC_W'(TICK_DIV - 1));
    last_c   = (idx_q == IDX_W'(NUM_DIGITS - 1));
    load_c   = start_q | (tick_c & last_c);
    presc_d  = presc_q + PRESC_W'(1);
    idx_d    = idx_q;
    pwm_d    = pwm_q + BRIGHT_W'(1);
    start_d  = 1'b0;
    val_sh_d = val_sh_q;
    dp_sh_d  = dp_sh_q;
    en_sh_d  = en_sh_q;
    br_sh_d  = br_sh_q;
    if (start_q) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (tick_c) begin
      presc_d = '0;
      idx_d   = last_c ? '0 : idx_q + IDX_W'(1);
    end
    if (load_c) begin
      val_sh_d = value;
      dp_sh_d  = dp_in;
      en_sh_d  = digit_en;
      br_sh_d  = brightness;
    end
  end

  // Leading-zero blanking: a digit is blanked while every digit from the top
  // down to it (inclusive) is a zero nibble with no decimal point.
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic lead_c;
  always_comb begin
    blank_c = '0;
    lead_c  = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      lead_c     = lead_c & (val_sh_q[4*k +: 4] == 4'h0) & ~dp_sh_q[k];
      blank_c[k] = lead_c;
    end
  end
`else
  always_comb begin
    blank_c = '0;
  end
`endif

  // Select the active digit and decide its visibility.
  always_comb begin
    nib_c       = 4'h0;
    en_bit_c    = 1'b0;
    dp_bit_c    = 1'b0;
    blank_bit_c = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_c       = val_sh_q[4*k +: 4];
        en_bit_c    = en_sh_q[k];
        dp_bit_c    = dp_sh_q[k];
        blank_bit_c = blank_c[k];
      end
    end
    gate_c = (br_sh_q == '1) | (pwm_q < br_sh_q);
    vis_c  = en_bit_c & ~blank_bit_c & gate_c;
  end

  // Next values of the registered outputs.
  always_comb begin
    an_d          = '1;
    seg_d         = 7'b1111111;
    dp_d          = ~dp_bit_c;
    frame_start_d = load_c;
    if (vis_c) begin
      an_d = ~(NUM_DIGITS'(1) << idx_q);
    end
    case (nib_c)
      4'h0: seg_d = 7'b0000001;
      4'h1: seg_d = 7'b1001111;
      4'h2: seg_d = 7'b0010010;
      4'h3: seg_d = 7'b0000110;
      4'h4: seg_d = 7'b1001100;
      4'h5: seg_d = 7'b0100100;
      4'h6: seg_d = 7'b0100000;
      4'h7: seg_d = 7'b0001111;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0000100;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b1100000;
      4'hC: seg_d = 7'b0110001;
      4'hD: seg_d = 7'b1000010;
      4'hE: seg_d = 7'b0110000;
      4'hF: seg_d = 7'b0111000;
      default: seg_d = 7'b1111111;
    endcase
  end

  // State register. start_q marks the first cycle after reset release.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      presc_q       <= '0;
      idx_q         <= '0;
      pwm_q         <= '0;
      start_q       <= 1'b1;
      val_sh_q      <= '0;
      dp_sh_q       <= '0;
      en_sh_q       <= '0;
      br_sh_q       <= '0;
      an_q          <= '1;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pwm_q         <= pwm_d;
      start_q       <= start_d;
      val_sh_q      <= val_sh_d;
      dp_sh_q       <= dp_sh_d;
      en_sh_q       <= en_sh_d;
      br_sh_q       <= br_sh_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver (4 digits, TICK_DIV=4, BRIGHT_W=2).
// A reference process predicts each cycle's outputs from edge counts and frame
// arithmetic, and queues them. A monitor process compares them on the falling edge.
module tb_seg7_scan_driver;

  localparam int unsigned N     = 4;
  localparam int unsigned TD    = 4;
  localparam int unsigned BW    = 2;
  localparam int unsigned FRAME = N * TD;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [4*N-1:0] value = '0;
  logic [N-1:0]   dp_in = '0;
  logic [N-1:0]   digit_en = '0;
  logic [BW-1:0]  brightness = '0;
  logic [N-1:0]   an;
  logic [6:0]     seg;
  logic           dp;
  logic           frame_start;

  seg7_scan_driver #(.NUM_DIGITS(N), .TICK_DIV(TD), .BRIGHT_W(BW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .value       (value),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .brightness  (brightness),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         fs;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference state: edges since reset release plus the latched frame snapshot.
  int unsigned    edges = 0;
  logic [4*N-1:0] sh_val = '0;
  logic [N-1:0]   sh_dp = '0;
  logic [N-1:0]   sh_en = '0;
  logic [BW-1:0]  sh_br = '0;

  function automatic logic [3:0] nib_of(int unsigned k);
    logic [4*N-1:0] v;
    v = sh_val >> (4 * k);
    return v[3:0];
  endfunction

  // Display seen after the next edge, given that `e` edges have elapsed since release.
  function automatic exp_t predict(int unsigned e);
    exp_t        r;
    int unsigned idx;
    int unsigned pwm;
    bit          blank;
    bit          vis;
    idx   = (e == 0) ? 0 : ((e - 1) / TD) % N;
    pwm   = e % (1 << BW);
    blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank = (idx != 0);
    for (int unsigned j = idx; j < N; j++) begin
      if (nib_of(j) != 4'h0 || sh_dp[j]) blank = 1'b0;
    end
`endif
    vis   = sh_en[idx] && !blank && ((sh_br == {BW{1'b1}}) || (pwm < int'(sh_br)));
    r.an  = vis ? ~(N'(1) << idx) : {N{1'b1}};
    r.seg = seg_tab[nib_of(idx)];
    r.dp  = ~sh_dp[idx];
    r.fs  = 1'b0;
    return r;
  endfunction

  // Reference model: one prediction per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge aclk);
      if (!aresetn) begin
        edges  = 0;
        sh_val = '0;
        sh_dp  = '0;
        sh_en  = '0;
        sh_br  = '0;
        e.an   = {N{1'b1}};
        e.seg  = 7'b1111111;
        e.dp   = 1'b1;
        e.fs   = 1'b0;
      end else begin
        e     = predict(edges);
        edges = edges + 1;
        e.fs  = (((edges - 1) % FRAME) == 0);
        if (e.fs) begin
          sh_val = value;
          sh_dp  = dp_in;
          sh_en  = digit_en;
          sh_br  = brightness;
        end
      end
      exp_q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; pop and compare each one.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("an", 32'(an), 32'(e.an));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("dp", 32'(dp), 32'(e.dp));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  task automatic cyc(input int unsigned k);
    repeat (k) @(posedge aclk);
    #1;
  endtask

  initial begin
    bit found;
    value      = 16'h1A3F;
    dp_in      = 4'h0;
    digit_en   = 4'hF;
    brightness = 2'b11;
    aresetn    = 1'b0;
    cyc(3);
    aresetn = 1'b1;
    cyc(2 * FRAME);

    // Mid-frame change must wait for the next frame load.
    cyc(6);
    value = 16'h0000;
    cyc(2 * FRAME);

    // Brightness duty, then fully dark.
    value      = 16'h1A3F;
    brightness = 2'b01;
    cyc(2 * FRAME);
    brightness = 2'b00;
    cyc(2 * FRAME);

    // Enable mask and decimal point.
    brightness = 2'b11;
    digit_en   = 4'b0101;
    dp_in      = 4'b0100;
    cyc(2 * FRAME);

    // Leading zeros (blanked only when the feature is built in).
    digit_en = 4'hF;
    dp_in    = 4'h0;
    value    = 16'h0005;
    cyc(2 * FRAME);
    value = 16'h0000;
    cyc(2 * FRAME);
    value = 16'h0050;
    dp_in = 4'b0100;
    cyc(2 * FRAME);

    // Reset mid-slot while digit 2 is active.
    found = 1'b0;
    for (int i = 0; i < int'(FRAME) + 2 && !found; i++) begin
      if (edges > 0 && ((edges - 1) % FRAME) == 2 * TD + 1) found = 1'b1;
      else cyc(1);
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_align: actual=not_reached required=digit2_slot");
    end
    aresetn = 1'b0;
    cyc(1);
    aresetn = 1'b1;
    cyc(2 * FRAME);

    // Randomized inputs with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) value = 16'($urandom);
      if ($urandom_range(0, 5) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 5) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 7) == 0) brightness = 2'($urandom);
      aresetn = ($urandom_range(0, 99) != 0);
      cyc(1);
    end
    aresetn = 1'b1;
    cyc(3);
    @(negedge aclk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment scan driver for board-level debug readout of physics-core state (ball/paddle coordinates) on common-anode displays. It generalises the fixed 8-digit hex display to NUM_DIGITS digits and adds several features:
- per-digit decimal points and enable mask;
- PWM brightness control;
- frame-coherent input latching, so a frame never mixes old and new values;
- a frame-boundary strobe.

It sits in the board top, fed directly from core output buses.

## Interface

Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 1..16.
- TICK_DIV, 200000, aclk cycles per digit slot; must be ≥ 2.
- BRIGHT_W, 4, width of the brightness control.

Ports:
- aclk  in  1  system clock. One clock domain only.
- aresetn  in  1  reset, synchronous and active-low.
- value  in  4*NUM_DIGITS  hex nibbles. Digit k is value[4k+3:4k]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active high.
- digit_en  in  NUM_DIGITS  digit enable mask; a 0 bit blanks that digit.
- brightness  in  BRIGHT_W  duty control. 0 = dark, all-ones = full on.
- an  out  NUM_DIGITS  anode selects, active low.
- seg  out  7  segments {a,b,c,d,e,f,g}, active low.
- dp  out  1  decimal point segment, active low.
- frame_start  out  1  one-cycle pulse when the shadow registers load.

## Operation

Counters:
- Prescaler: counts 0..TICK_DIV-1 and wraps.
- Digit index: advances at prescaler == TICK_DIV-1 and wraps NUM_DIGITS-1 → 0.
- PWM counter: free-running, BRIGHT_W bits, increments every cycle.

Frame load:
- frame_start asserts on the first cycle after reset release.
- It also asserts when prescaler == TICK_DIV-1 and index == NUM_DIGITS-1.
- On a frame_start cycle, value, dp_in, digit_en and brightness are copied into shadow registers. All display decisions use the shadow copies only.

Digit output:
- The active digit is the current index.
- an has exactly one bit low (bit = index) when the digit is visible; otherwise all ones.
- A digit is visible when all of the following hold:
  - shadow digit_en[index] = 1;
  - the digit is not blanked by the configuration feature;
  - the PWM gate is open.
- PWM gate is open when shadow brightness is all-ones, or when pwm_cnt < shadow brightness.
- seg decodes the active nibble: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- dp = ~shadow dp_in[index].
- seg and dp are driven even when an is all ones.

## Timing

Reset values:
- an = all ones, seg = 7'b1111111, dp = 1, frame_start = 0.
- Prescaler, index, pwm_cnt and all shadow registers = 0.

Latency and periods:
- an, seg and dp are registered. They reflect the index and shadow state one cycle after those update.
- Digit slot lasts TICK_DIV cycles; frame period is NUM_DIGITS*TICK_DIV cycles.
- An input change becomes visible 1 cycle after the next frame_start that samples it.

Boundary conditions:
- Inputs that change between frame loads are ignored until the next load.
- NUM_DIGITS = 1: index stays 0 and frame_start fires every TICK_DIV cycles.
- brightness = 0: an stays all ones throughout the frame.
- Reset asserted mid-frame: all state returns to the reset values at the next edge. The first cycle after release pulses frame_start.

## Configuration

Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: leading-zero blanking is applied on the shadow copy.
  - Scanning from digit NUM_DIGITS-1 downward, each digit whose nibble is 0 and whose shadow dp_in bit is 0 is blanked.
  - Blanking stops at the first nonzero nibble or the first set dp bit.
  - Digit 0 is never blanked.
- Undefined: no blanking logic exists; zeros display as "0".

## Test plan

Bench configuration: NUM_DIGITS=4, TICK_DIV=4, BRIGHT_W=2.

- Reset then release:
  - stimulus: value=16'h1A3F, digit_en=4'hF, brightness=2'b11;
  - response: frame_start pulses on cycle 1; an sequence 1110, 1101, 1011, 0111, each held 4 cycles; seg sequence F=0111000, 3, A, 1.
- Coherent latch:
  - stimulus: change value to 16'h0000 mid-frame;
  - response: the current frame still shows 1A3F; zeros appear only after the next frame_start.
- Brightness:
  - stimulus: brightness=2'b01;
  - response: an active-low for exactly 1 of every 4 cycles within each slot; brightness=0 keeps an = 1111 for an entire frame.
- Mask and decimal point:
  - stimulus: digit_en=4'b0101, dp_in=4'b0100;
  - response: slots for digits 1 and 3 drive an=1111; dp=0 only while digit 2 is selected.
- Leading-zero blanking, macro defined:
  - stimulus: value=16'h0005;
  - response: digits 3–1 blanked, digit 0 shows 5.
  - stimulus: value=16'h0000;
  - response: digit 0 shows 0.
  - Macro undefined: all four digits shown.
- Reset mid-slot at digit 2:
  - response: next edge gives an=1111 and seg=1111111; scan restarts at digit 0 with a frame_start pulse.
